// File: rtl/alu_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : alu_pkg
// Purpose : Shared definitions for the execute-stage arithmetic blocks.
//           Holds the M-extension divide op encodings (funct3[1:0]), the
//           divider state encoding and the special-result constants.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package alu_pkg;

  // funct3[1:0] of DIV/DIVU/REM/REMU
  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  // Special-result constants
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  // DIV and REM are the signed forms; bit 0 of the op selects unsigned.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM/REMU return the remainder; DIV/DIVU return the quotient.
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/add32.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : add32
// Purpose : 32-bit ripple-carry adder shared with the ALU. The divider uses
//           it as a subtractor by feeding the inverted divisor on b and
//           forcing c_1 (carry into bit 0) to 1.
// Ports   : a    in  32  first operand
//           b    in  32  second operand
//           c_1  in  1   carry into bit 0
//           s    out 32  sum
//           c31  out 1   carry out of bit 31
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_1,
  output logic [31:0] s,
  output logic        c31
);

  // carry[i] is the carry out of bit i; carry_in[i] feeds bit i.
  logic [31:0] carry;
  logic [31:0] carry_in;

  assign carry_in[0] = c_1;

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_bit
      assign s[i]     = a[i] ^ b[i] ^ carry_in[i];
      assign carry[i] = (a[i] & b[i]) | (carry_in[i] & (a[i] ^ b[i]));
      if (i < 31) begin : g_chain
        assign carry_in[i+1] = carry[i];
      end
    end
  endgenerate

  assign c31 = carry[31];

endmodule : add32
`default_nettype wire

// File: rtl/div32.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : div32
// Purpose : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//           One quotient bit per clock; the trial subtraction runs through
//           add32 with an inverted divisor and carry-in of 1. Operands are
//           reduced to magnitudes on entry and the sign is fixed up when
//           the result is registered.
// Ports   : clk     in  1   clock, rising edge
//           rst     in  1   asynchronous active-high reset
//           start   in  1   request, honoured only while idle
//           op      in  2   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//           a       in  32  dividend, sampled with start
//           b       in  32  divisor, sampled with start
//           busy    out 1   operation in flight (low in the done cycle)
//           done    out 1   one-cycle pulse, result valid in that cycle
//           result  out 32  quotient or remainder, held until next FIN
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module div32
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  //--------------------------------------------------------------------------
  // State
  //--------------------------------------------------------------------------
  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            sgn_quo_q, sgn_quo_d;   // negate quotient at FIN
  logic            sgn_rem_q, sgn_rem_d;   // negate remainder at FIN
  logic [XLEN-1:0] quo_q, quo_d;           // dividend shifts out, quotient in
  logic [XLEN-1:0] rem_q, rem_d;           // partial remainder
  logic [XLEN-1:0] div_q, div_d;           // divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  //--------------------------------------------------------------------------
  // Operand conditioning
  //--------------------------------------------------------------------------
  logic            in_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero;
  logic            sgn_ovf;

  assign in_signed = op_is_signed(op);
  assign a_neg     = in_signed & a[XLEN-1];
  assign b_neg     = in_signed & b[XLEN-1];
  // |INT_MIN| wraps to INT_MIN, which is the correct unsigned magnitude.
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  assign div_by_zero = (b == '0);
  assign sgn_ovf     = in_signed & (a == INT_MIN) & (b == ALL_ONES);

  //--------------------------------------------------------------------------
  // Trial subtraction: t = {rem, quo} << 1 (upper 33 bits), diff = t - div
  //--------------------------------------------------------------------------
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff;
  logic            diff_c31;
  logic            take;

  assign trial = {rem_q, quo_q[XLEN-1]};

  add32 u_sub (
    .a   (trial[XLEN-1:0]),
    .b   (~div_q),
    .c_1 (1'b1),
    .s   (diff),
    .c31 (diff_c31)
  );

  // A no-borrow carry means t[31:0] >= div; if t[32] is set, t already
  // exceeds any 32-bit divisor and the wrapped diff is still exact.
  assign take = trial[XLEN] | diff_c31;

  //--------------------------------------------------------------------------
  // Sign fix for the final result
  //--------------------------------------------------------------------------
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign quo_fix = sgn_quo_q ? -quo_q : quo_q;
  assign rem_fix = sgn_rem_q ? -rem_q : rem_q;

  //--------------------------------------------------------------------------
  // Next-state and datapath
  //--------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          sgn_quo_d = a_neg ^ b_neg;
          sgn_rem_d = a_neg;
          quo_d     = a_mag;
          rem_d     = '0;
          div_d     = b_mag;
          cnt_d     = '0;
          if (div_by_zero) begin
            // Quotient all ones, remainder is the raw dividend, no fix-up.
            quo_d     = ALL_ONES;
            rem_d     = a;
            sgn_quo_d = 1'b0;
            sgn_rem_d = 1'b0;
            state_d   = FIN;
          end else if (sgn_ovf) begin
            quo_d     = INT_MIN;
            rem_d     = '0;
            sgn_quo_d = 1'b0;
            sgn_rem_d = 1'b0;
            state_d   = FIN;
          end else begin
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        rem_d = take ? diff : trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], take};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = FIN;
        end
      end

      FIN: begin
        result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule : div32
`default_nettype wire
